atm_keypad_tx: RTL and testbench
================================

Name: atm_keypad_tx

Overview:
- Keypad front-end that drives the ATM controller's entry interface.
- Debounces a raw keypad strobe and decodes keys into a one-cycle event per press.
- Emits the PIN digit stream (digito / add_digit / digito_stb).
- Assembles decimal amounts into binary and emits monto / monto_stb.
- Sits between the keypad matrix decoder and the ATM controller, on the same clk domain.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized key level must differ from the accepted level before it flips (min 1).
- PIN_DIGITS, 4, digits required before ENTER is accepted in PIN mode.
- MAX_AMOUNT, 32'd99999999, largest amount accepted in amount mode.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- key_press  input  1  raw key-down level from the matrix decoder; asynchronous to clk
- key_code  input  4  key id, stable while key_press high: 0-9 digits, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, others ignored
- start  input  1  one-cycle request to open an entry session; honoured only in IDLE
- mode_pin  input  1  sampled with start: 1 = PIN entry, 0 = amount entry
- digito  output  4  last PIN digit sent; holds between events
- add_digit  output  1  one-cycle pulse, digito valid
- digito_stb  output  1  one-cycle pulse, PIN complete
- monto  output  32  last completed amount, binary; holds until next monto_stb
- monto_stb  output  1  one-cycle pulse, monto valid
- entry_error  output  1  one-cycle pulse on a rejected key
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, counters and accumulator 0, accepted key level 0.
- Input synchronization: key_press passes through a 2-FF synchronizer.
- Debounce: a counter runs while the synchronized level differs from the accepted level and clears when they match. When it reaches DEBOUNCE_CYCLES, the accepted level flips.
- Key event: a 0->1 flip of the accepted level raises key_evt for one cycle and captures key_code. A 1->0 flip raises no event, so a held key yields exactly one event.
- Latency: a key held stable produces its registered output pulse DEBOUNCE_CYCLES+3 rising edges after key_press is first sampled high.
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- IDLE:
  - start: go to PIN if mode_pin=1, otherwise AMOUNT; clear pin_cnt and acc.
  - Key events are ignored. A key event coincident with start is discarded.
- PIN:
  - Digit with pin_cnt<PIN_DIGITS: digito<=code, add_digit pulse, pin_cnt++.
  - Digit with pin_cnt==PIN_DIGITS: ignored, entry_error pulse.
  - ENTER with pin_cnt==PIN_DIGITS: digito_stb pulse, pin_cnt<=0, stay in PIN, since the controller may request a retry.
  - ENTER with pin_cnt<PIN_DIGITS: entry_error pulse, pin_cnt unchanged.
  - CLEAR: pin_cnt<=0, no output.
  - CANCEL: go to IDLE.
- AMOUNT:
  - Digit: next = acc*10 + d, computed as (acc<<3)+(acc<<1)+d in 36 bits.
  - If next <= MAX_AMOUNT: acc<=next[31:0], ndig++. Otherwise the digit is ignored and entry_error pulses.
  - ENTER with ndig>0: monto<=acc, monto_stb pulse, go to IDLE.
  - ENTER with ndig==0: entry_error pulse.
  - CLEAR: acc<=0, ndig<=0.
  - CANCEL: go to IDLE, monto unchanged.
- Undefined key codes (0xD-0xF): ignored, no error.
- start outside IDLE: ignored.
- Reset mid-session: immediate return to IDLE; any partial PIN or amount is discarded and no strobe is emitted.
- At most one of add_digit / digito_stb / monto_stb / entry_error is high in any cycle.

Decomposition:
- Shared package atm_pkg holds:
  - key code constants: KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_CANCEL=4'hC
  - entry state encodings: IDLE=0, PIN=1, AMOUNT=2
  - shared widths: DIGIT_W=4, MONTO_W=32
- One sub-module, key_debouncer:
  - contains the synchronizer, the debounce counter and the rising-flip event generator
  - parameter: DEBOUNCE_CYCLES
  - outputs: key_evt, key_code_q
- The top level holds the entry FSM, pin_cnt, acc/ndig and the output registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset and debounce:
  - Stimulus: rst=0 mid-stream, release; then start with mode_pin=1 and press key 7 held for 20 cycles.
  - Required: all outputs 0 during reset; exactly one add_digit with digito=7, 7 edges after the press; no second pulse while the key is held.
- Glitch rejection:
  - Stimulus: in PIN mode, key_press high for 2 cycles then low.
  - Required: no add_digit.
- PIN flow:
  - Stimulus: start with mode_pin=1; keys 4,7,5,6,5 then ENTER.
  - Required: four add_digit pulses carrying 4,7,5,6; the fifth digit gives entry_error; ENTER gives digito_stb; busy stays 1.
  - Follow-up: ENTER after only 2 digits gives entry_error and no digito_stb.
- Amount flow:
  - Stimulus: start with mode_pin=0; keys 1,2,5,0, CLEAR, 3,0,0, ENTER.
  - Required: monto=300 with a monto_stb pulse; the state returns to IDLE and busy=0.
- Overflow:
  - Stimulus: amount mode; nine 9 digits then ENTER.
  - Required: the ninth digit gives entry_error; monto=99999999 with monto_stb.
- Cancel and collision:
  - Stimulus: CANCEL during amount entry; then in IDLE, start with mode_pin=0 asserted on the same cycle as a key event.
  - Required: CANCEL returns to IDLE with no monto_stb; the coincident key event is dropped and acc stays 0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared key codes, entry-state encoding and widths for the ATM keypad front-end.
package atm_pkg;

    localparam int DIGIT_W = 4;
    localparam int MONTO_W = 32;

    localparam logic [DIGIT_W-1:0] KEY_ENTER  = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR  = 4'hB;
    localparam logic [DIGIT_W-1:0] KEY_CANCEL = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PIN    = 2'd1,
        AMOUNT = 2'd2
    } entry_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes the raw key level, debounces it and emits one key_evt per accepted press.
module key_debouncer
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_press,
    input  logic [DIGIT_W-1:0] key_code,
    output logic               key_evt,
    output logic [DIGIT_W-1:0] key_code_q
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The flip happens on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    assign flip = (sync2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            key_evt    <= 1'b0;
            key_code_q <= '0;
        end else begin
            sync1   <= key_press;
            sync2   <= sync1;
            key_evt <= flip && !level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (flip && !level) begin
                key_code_q <= key_code;
            end
        end
    end

endmodule

// File: rtl/atm_keypad_tx.sv
// Keypad entry front-end: turns debounced key events into PIN digits and binary amounts.
//   state  | meaning
//   IDLE   | no session open; waits for start
//   PIN    | collecting PIN digits, ENTER releases the PIN strobe
//   AMOUNT | accumulating a decimal amount, ENTER releases monto
module atm_keypad_tx
    import atm_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter int                 PIN_DIGITS      = 4,
    parameter logic [MONTO_W-1:0] MAX_AMOUNT      = 32'd99999999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_press,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               start,
    input  logic               mode_pin,
    output logic [DIGIT_W-1:0] digito,
    output logic               add_digit,
    output logic               digito_stb,
    output logic [MONTO_W-1:0] monto,
    output logic               monto_stb,
    output logic               entry_error,
    output logic               busy
);

    localparam int PCNT_W = $clog2(PIN_DIGITS + 1);
    localparam int AMT_W  = MONTO_W + 4;

    logic               key_evt;
    logic [DIGIT_W-1:0] key_code_q;

    entry_state_t       state_q, state_d;
    logic [PCNT_W-1:0]  pin_cnt, pin_cnt_d;
    logic [MONTO_W-1:0] acc, acc_d;
    logic [3:0]         ndig, ndig_d;
    logic [DIGIT_W-1:0] digito_d;
    logic [MONTO_W-1:0] monto_d;
    logic               add_d, dstb_d, mstb_d, err_d;

    logic               is_digit;
    logic               pin_full;
    logic [AMT_W-1:0]   acc_x;
    logic [AMT_W-1:0]   next_amt;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk       (clk),
        .rst       (rst),
        .key_press (key_press),
        .key_code  (key_code),
        .key_evt   (key_evt),
        .key_code_q(key_code_q)
    );

    assign is_digit = (key_code_q <= 4'd9);
    assign pin_full = (pin_cnt == PCNT_W'(PIN_DIGITS));
    assign acc_x    = {4'b0000, acc};
    // acc*10 + d without a multiplier; 36 bits cannot overflow for a 32-bit acc.
    assign next_amt = (acc_x << 3) + (acc_x << 1) + {{MONTO_W{1'b0}}, key_code_q};

    always_comb begin
        state_d   = state_q;
        pin_cnt_d = pin_cnt;
        acc_d     = acc;
        ndig_d    = ndig;
        digito_d  = digito;
        monto_d   = monto;
        add_d     = 1'b0;
        dstb_d    = 1'b0;
        mstb_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = mode_pin ? PIN : AMOUNT;
                    pin_cnt_d = '0;
                    acc_d     = '0;
                    ndig_d    = '0;
                end
            end

            PIN: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (pin_full) begin
                            err_d = 1'b1;
                        end else begin
                            digito_d  = key_code_q;
                            add_d     = 1'b1;
                            pin_cnt_d = pin_cnt + PCNT_W'(1);
                        end
                    end else begin
                        case (key_code_q)
                            KEY_ENTER: begin
                                if (pin_full) begin
                                    dstb_d    = 1'b1;
                                    pin_cnt_d = '0;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            KEY_CLEAR:  pin_cnt_d = '0;
                            KEY_CANCEL: state_d   = IDLE;
                            default: ;
                        endcase
                    end
                end
            end

            AMOUNT: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (next_amt <= {4'b0000, MAX_AMOUNT}) begin
                            acc_d = next_amt[MONTO_W-1:0];
                            // Saturate so long runs of leading zeros keep ndig non-zero.
                            if (ndig != 4'hF) begin
                                ndig_d = ndig + 4'd1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code_q)
                            KEY_ENTER: begin
                                if (ndig != 4'd0) begin
                                    monto_d = acc;
                                    mstb_d  = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            KEY_CLEAR: begin
                                acc_d  = '0;
                                ndig_d = '0;
                            end
                            KEY_CANCEL: state_d = IDLE;
                            default: ;
                        endcase
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pin_cnt     <= '0;
            acc         <= '0;
            ndig        <= '0;
            digito      <= '0;
            monto       <= '0;
            add_digit   <= 1'b0;
            digito_stb  <= 1'b0;
            monto_stb   <= 1'b0;
            entry_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pin_cnt     <= pin_cnt_d;
            acc         <= acc_d;
            ndig        <= ndig_d;
            digito      <= digito_d;
            monto       <= monto_d;
            add_digit   <= add_d;
            digito_stb  <= dstb_d;
            monto_stb   <= mstb_d;
            entry_error <= err_d;
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_atm_keypad_tx.sv
// Directed bench for atm_keypad_tx with a short debounce window.
module tb_atm_keypad_tx;
    import atm_pkg::*;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic        key_press;
    logic [3:0]  key_code;
    logic        start;
    logic        mode_pin;
    logic [3:0]  digito;
    logic        add_digit;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic        entry_error;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_add   = 0;
    int n_dstb  = 0;
    int n_mstb  = 0;
    int n_err   = 0;
    int n_multi = 0;

    atm_keypad_tx #(
        .DEBOUNCE_CYCLES(DEB),
        .PIN_DIGITS     (4),
        .MAX_AMOUNT     (32'd99999999)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_press  (key_press),
        .key_code   (key_code),
        .start      (start),
        .mode_pin   (mode_pin),
        .digito     (digito),
        .add_digit  (add_digit),
        .digito_stb (digito_stb),
        .monto      (monto),
        .monto_stb  (monto_stb),
        .entry_error(entry_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        n_add  += int'(add_digit);
        n_dstb += int'(digito_stb);
        n_mstb += int'(monto_stb);
        n_err  += int'(entry_error);
        if (int'(add_digit) + int'(digito_stb) + int'(monto_stb) + int'(entry_error) > 1)
            n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_session(input logic m);
        @(negedge clk);
        start    = 1'b1;
        mode_pin = m;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] code);
        @(negedge clk);
        key_code  = code;
        key_press = 1'b1;
        repeat (10) @(negedge clk);
        key_press = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    int a0, d0, m0, e0;
    int first_i, hits;
    logic [3:0] pin_seq [4];

    initial begin
        rst       = 1'b0;
        key_press = 1'b0;
        key_code  = 4'd0;
        start     = 1'b0;
        mode_pin  = 1'b0;
        pin_seq   = '{4'd4, 4'd7, 4'd5, 4'd6};

        repeat (3) @(negedge clk);
        check("rst_flags", {27'd0, digito, add_digit, digito_stb, monto_stb, entry_error, busy}, 32'd0);
        check("rst_monto", monto, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a PIN session
        start_session(1'b1);
        press_key(4'd3);
        check("pre_rst_digito", digito, 32'd3);
        check("pre_rst_busy", busy, 32'd1);
        a0 = n_add; d0 = n_dstb;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_flags", {27'd0, digito, add_digit, digito_stb, monto_stb, entry_error, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_no_strobe", n_dstb - d0, 32'd0);

        // Latency and single event for a held key
        start_session(1'b1);
        @(negedge clk);
        key_code  = 4'd7;
        key_press = 1'b1;
        first_i   = 0;
        hits      = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (add_digit) begin
                hits++;
                if (first_i == 0) first_i = i;
            end
        end
        key_press = 1'b0;
        repeat (10) @(negedge clk);
        check("latency_edges", first_i, DEB + 3);
        check("held_one_pulse", hits, 32'd1);
        check("held_digito", digito, 32'd7);
        check("held_busy", busy, 32'd1);

        // Two-cycle glitch must not pass the debouncer
        a0 = n_add;
        @(negedge clk);
        key_code  = 4'd2;
        key_press = 1'b1;
        repeat (2) @(negedge clk);
        key_press = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_no_add", n_add - a0, 32'd0);
        press_key(KEY_CANCEL);
        check("cancel_pin_busy", busy, 32'd0);

        // PIN flow
        start_session(1'b1);
        a0 = n_add; d0 = n_dstb; e0 = n_err;
        for (int i = 0; i < 4; i++) begin
            press_key(pin_seq[i]);
            check("pin_digito", digito, pin_seq[i]);
        end
        check("pin_add_count", n_add - a0, 32'd4);
        press_key(4'd5);
        check("pin_fifth_err", n_err - e0, 32'd1);
        check("pin_fifth_digito", digito, 32'd6);
        check("pin_fifth_no_add", n_add - a0, 32'd4);
        press_key(KEY_ENTER);
        check("pin_enter_stb", n_dstb - d0, 32'd1);
        check("pin_busy_stays", busy, 32'd1);
        press_key(4'd1);
        press_key(4'd2);
        press_key(KEY_ENTER);
        check("pin_short_err", n_err - e0, 32'd2);
        check("pin_short_no_stb", n_dstb - d0, 32'd1);
        press_key(KEY_CLEAR);
        press_key(4'd9);
        press_key(4'd8);
        press_key(4'd7);
        press_key(4'd6);
        press_key(KEY_ENTER);
        check("pin_after_clear_stb", n_dstb - d0, 32'd2);
        a0 = n_add;
        start_session(1'b0);
        press_key(4'd1);
        check("start_ignored_in_pin", n_add - a0, 32'd1);
        press_key(KEY_CANCEL);
        check("pin_cancel_busy", busy, 32'd0);

        // Amount flow
        start_session(1'b0);
        m0 = n_mstb; e0 = n_err;
        press_key(KEY_ENTER);
        check("amt_empty_enter_err", n_err - e0, 32'd1);
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd5);
        press_key(4'd0);
        press_key(KEY_CLEAR);
        press_key(4'hD);
        press_key(4'd3);
        press_key(4'd0);
        press_key(4'd0);
        check("amt_no_extra_err", n_err - e0, 32'd1);
        press_key(KEY_ENTER);
        check("amt_monto", monto, 32'd300);
        check("amt_stb", n_mstb - m0, 32'd1);
        check("amt_busy_idle", busy, 32'd0);

        // Overflow at the ninth digit
        start_session(1'b0);
        m0 = n_mstb; e0 = n_err;
        for (int i = 0; i < 9; i++) press_key(4'd9);
        check("ovf_err", n_err - e0, 32'd1);
        press_key(KEY_ENTER);
        check("ovf_monto", monto, 32'd99999999);
        check("ovf_stb", n_mstb - m0, 32'd1);

        // Cancel during amount entry
        start_session(1'b0);
        m0 = n_mstb;
        press_key(4'd4);
        press_key(4'd2);
        press_key(KEY_CANCEL);
        check("amt_cancel_busy", busy, 32'd0);
        check("amt_cancel_no_stb", n_mstb - m0, 32'd0);
        check("amt_cancel_monto", monto, 32'd99999999);

        // start coincident with a key event: the key is dropped
        a0 = n_add; e0 = n_err;
        @(negedge clk);
        key_code  = 4'd5;
        key_press = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        start    = 1'b1;
        mode_pin = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        repeat (4) @(negedge clk);
        key_press = 1'b0;
        repeat (10) @(negedge clk);
        check("collide_busy", busy, 32'd1);
        check("collide_no_err", n_err - e0, 32'd0);
        press_key(KEY_ENTER);
        check("collide_acc_empty", n_err - e0, 32'd1);
        press_key(4'd3);
        m0 = n_mstb;
        press_key(KEY_ENTER);
        check("collide_monto", monto, 32'd3);
        check("collide_stb", n_mstb - m0, 32'd1);

        check("pulse_exclusive", n_multi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
